note_playback_sequencer: RTL and testbench

NOTE_PLAYBACK_SEQUENCER -- requirements
Module: note_playback_sequencer

---
 rtl/note_playback_sequencer_pkg.sv | 30 +++
 rtl/note_playback_sequencer_time_reached_cmp.sv | 13 +
 rtl/note_playback_sequencer.sv | 131 +++++++++++++
 tb/tb_note_playback_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_playback_sequencer_pkg.sv
// Shared definitions for the note playback sequencer: FSM encoding,
// event-word layout and the song time limit.
package note_playback_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int EVENT_BITS  = 36;
    localparam int TS_BITS     = 29;
    localparam int EV_LAST_BIT = 35;
    localparam int EV_ON_BIT   = 34;
    localparam int EV_NOTE_MSB = 33;
    localparam int EV_NOTE_LSB = 29;
    localparam int EV_TS_MSB   = 28;
    localparam int EV_TS_LSB   = 0;

    localparam logic [TS_BITS-1:0] MAX_TIME_US = 29'd300_000_000;

    // A timestamp beyond the song limit marks the end of the song.
    function automatic logic past_song_end(input logic [EVENT_BITS-1:0] ev);
        return ev[EV_TS_MSB:EV_TS_LSB] > MAX_TIME_US;
    endfunction

endpackage

// File: rtl/note_playback_sequencer_time_reached_cmp.sv
// Unsigned 29-bit "time reached" compare between the running microsecond
// counter and the timestamp of the latched event.
module time_reached_cmp
    import note_playback_sequencer_pkg::*;
(
    input  logic [TS_BITS-1:0] timeNow,
    input  logic [TS_BITS-1:0] target,
    output logic               reached
);

    assign reached = (timeNow >= target);

endmodule

// File: rtl/note_playback_sequencer.sv
// Note playback sequencer: walks an external event memory (1-cycle
// synchronous read), waits for each event's timestamp against the upstream
// microsecond counter, and emits one noteValid pulse per event.
//
// state | meaning
// IDLE  | not playing, waiting for start
// FETCH | rdAddr presented to the event memory
// LOAD  | rdData valid; latch event word, detect end-of-song timestamp
// WAIT  | hold until timeNow reaches the latched timestamp
// EMIT  | noteValid high; advance address or finish
// DONE  | song finished, waiting for a restart
module note_playback_sequencer
    import note_playback_sequencer_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int NOTE_BITS = 5
)
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [TS_BITS-1:0]    timeNow,
    output logic [ADDR_BITS-1:0]  rdAddr,
    input  logic [EVENT_BITS-1:0] rdData,
    output logic                  timerEnable,
    output logic                  timerClear,
    output logic                  noteValid,
    output logic [NOTE_BITS-1:0]  noteIndex,
    output logic                  noteOn,
    output logic                  busy,
    output logic                  done
);

    state_t                state;
    logic [EVENT_BITS-1:0] event_q;
    logic                  reached;
    logic                  last_addr;
    logic                  song_last;
    logic                  in_busy;

    time_reached_cmp u_time_reached_cmp (
        .timeNow (timeNow),
        .target  (event_q[EV_TS_MSB:EV_TS_LSB]),
        .reached (reached)
    );

    // The top address is forced to be the final event so rdAddr never wraps.
    assign last_addr = (rdAddr == '1);
    assign song_last = event_q[EV_LAST_BIT] | last_addr;
    assign in_busy   = (state != IDLE) && (state != DONE);

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state       <= IDLE;
            rdAddr      <= '0;
            event_q     <= '0;
            timerEnable <= 1'b0;
            timerClear  <= 1'b0;
            noteValid   <= 1'b0;
            noteIndex   <= '0;
            noteOn      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            timerClear <= 1'b0;
            noteValid  <= 1'b0;
            if (stop && in_busy) begin
                state       <= IDLE;
                timerEnable <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        // stop has priority over a simultaneous start
                        if (start && !stop) begin
                            state       <= FETCH;
                            rdAddr      <= '0;
                            timerClear  <= 1'b1;
                            timerEnable <= 1'b1;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                        end
                    end
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        event_q <= rdData;
                        if (past_song_end(rdData)) begin
                            state       <= DONE;
                            timerEnable <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (reached) begin
                            state     <= EMIT;
                            noteValid <= 1'b1;
                            noteIndex <= NOTE_BITS'(event_q[EV_NOTE_MSB:EV_NOTE_LSB]);
                            noteOn    <= event_q[EV_ON_BIT];
                        end
                    end
                    EMIT: begin
                        if (song_last) begin
                            state       <= DONE;
                            timerEnable <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            state  <= FETCH;
                            rdAddr <= rdAddr + ADDR_BITS'(1);
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        timerEnable <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_playback_sequencer.sv
// Directed bench for note_playback_sequencer. Expected notes are queued when
// a song is started; negedge monitors pop and compare on every noteValid.
module tb_note_playback_sequencer;

    typedef struct {
        logic [4:0] note;
        logic       on;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic        resetn = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic [28:0] timeNow = '0;
    logic [7:0]  rdAddr;
    logic [35:0] rdData;
    logic        timerEnable, timerClear, noteValid, noteOn, busy, done;
    logic [4:0]  noteIndex;

    // DUT B: 2-bit address space
    logic        start_b = 1'b0, stop_b = 1'b0;
    logic [28:0] timeNow_b = '0;
    logic [1:0]  rdAddr_b;
    logic [35:0] rdData_b;
    logic        timerEnable_b, timerClear_b, noteValid_b, noteOn_b, busy_b, done_b;
    logic [4:0]  noteIndex_b;

    logic [35:0] mem   [0:255];
    logic [35:0] mem_b [0:3];

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit left_zero_b = 1'b0;
    bit wrap_b      = 1'b0;

    note_playback_sequencer dut_a (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .timeNow(timeNow),
        .rdAddr(rdAddr), .rdData(rdData), .timerEnable(timerEnable), .timerClear(timerClear),
        .noteValid(noteValid), .noteIndex(noteIndex), .noteOn(noteOn), .busy(busy), .done(done)
    );

    note_playback_sequencer #(.ADDR_BITS(2), .NOTE_BITS(5)) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .stop(stop_b), .timeNow(timeNow_b),
        .rdAddr(rdAddr_b), .rdData(rdData_b), .timerEnable(timerEnable_b), .timerClear(timerClear_b),
        .noteValid(noteValid_b), .noteIndex(noteIndex_b), .noteOn(noteOn_b), .busy(busy_b), .done(done_b)
    );

    // synchronous-read event memories
    always @(posedge clk) begin
        rdData   <= mem[rdAddr];
        rdData_b <= mem_b[rdAddr_b];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [35:0] ev(input bit last, input bit on, input int note, input int ts);
        return {last, on, note[4:0], ts[28:0]};
    endfunction

    task automatic push_a(input int note, input bit on);
        exp_t e;
        e.note = note[4:0];
        e.on   = on;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int note, input bit on);
        exp_t e;
        e.note = note[4:0];
        e.on   = on;
        q_b.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ticks until the selected DUT shows noteValid; -1 when the budget runs out
    task automatic ticks_to_valid(input bit sel_b, input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            tick();
            n++;
            seen = sel_b ? noteValid_b : noteValid;
        end
        if (!seen) n = -1;
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            tick();
            if (noteValid) pulses++;
        end
    endtask

    // scoreboard monitor for DUT A
    always @(negedge clk) begin
        if (!resetn && noteValid) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_note_a: got note %0d on %0b, expected no pulse", noteIndex, noteOn);
            end else begin
                e_a = q_a.pop_front();
                check("note_a_index", 64'(noteIndex), 64'(e_a.note));
                check("note_a_on", 64'(noteOn), 64'(e_a.on));
            end
        end
    end

    // scoreboard monitor for DUT B, plus rdAddr wrap detection
    always @(negedge clk) begin
        if (!resetn) begin
            if (busy_b && rdAddr_b != 2'd0) left_zero_b <= 1'b1;
            if (busy_b && left_zero_b && rdAddr_b == 2'd0) wrap_b <= 1'b1;
            if (noteValid_b) begin
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_note_b: got note %0d on %0b, expected no pulse", noteIndex_b, noteOn_b);
                end else begin
                    e_b = q_b.pop_front();
                    check("note_b_index", 64'(noteIndex_b), 64'(e_b.note));
                    check("note_b_on", 64'(noteOn_b), 64'(e_b.on));
                end
            end
        end
    end

    initial begin
        int n;
        int p;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem_b[i] = '0;

        // ---------------- reset state ----------------
        repeat (2) tick();
        check("rst_rdAddr", 64'(rdAddr), 0);
        check("rst_timerEnable", 64'(timerEnable), 0);
        check("rst_timerClear", 64'(timerClear), 0);
        check("rst_noteValid", 64'(noteValid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_b_busy", 64'(busy_b), 0);
        resetn = 1'b0;
        tick();

        // ---------------- two-event song ----------------
        mem[0] = ev(0, 1, 0, 0);
        mem[1] = ev(1, 0, 0, 10);
        push_a(0, 1);
        push_a(0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_timerClear", 64'(timerClear), 1);
        check("t1_timerEnable", 64'(timerEnable), 1);
        check("t1_busy", 64'(busy), 1);
        check("t1_rdAddr", 64'(rdAddr), 0);
        tick();
        check("t1_timerClear_one_cycle", 64'(timerClear), 0);
        ticks_to_valid(1'b0, 20, n);
        check("t1_first_note_latency", 64'(n), 2);
        count_pulses(6, p);
        check("t1_no_early_note", 64'(p), 0);
        timeNow = 29'd10;
        ticks_to_valid(1'b0, 5, n);
        check("t1_second_note_latency", 64'(n), 1);
        tick();
        check("t1_done", 64'(done), 1);
        check("t1_timerEnable_off", 64'(timerEnable), 0);
        check("t1_busy_off", 64'(busy), 0);
        check("t1_queue_drained", 64'(q_a.size()), 0);

        // ---------------- hold in WAIT, restart from DONE ----------------
        mem[0] = ev(0, 1, 3, 0);
        mem[1] = ev(1, 0, 3, 6);
        timeNow = 29'd5;
        push_a(3, 1);
        push_a(3, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_restart_rdAddr", 64'(rdAddr), 0);
        check("t2_restart_busy", 64'(busy), 1);
        check("t2_restart_done", 64'(done), 0);
        ticks_to_valid(1'b0, 10, n);
        check("t2_first_note_latency", 64'(n), 3);
        count_pulses(10, p);
        check("t2_hold_no_note", 64'(p), 0);
        check("t2_hold_busy", 64'(busy), 1);
        timeNow = 29'd6;
        ticks_to_valid(1'b0, 5, n);
        check("t2_step_latency", 64'(n), 1);
        tick();
        check("t2_done", 64'(done), 1);

        // ---------------- stop during WAIT, then replay ----------------
        mem[0] = ev(0, 1, 7, 0);
        mem[1] = ev(1, 0, 7, 1000);
        timeNow = 29'd0;
        push_a(7, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks_to_valid(1'b0, 10, n);
        check("t3_first_note_latency", 64'(n), 3);
        repeat (5) tick();
        check("t3_waiting_busy", 64'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t3_stop_busy", 64'(busy), 0);
        check("t3_stop_timerEnable", 64'(timerEnable), 0);
        check("t3_stop_noteValid", 64'(noteValid), 0);
        check("t3_stop_done", 64'(done), 0);
        timeNow = 29'd1000;
        count_pulses(8, p);
        check("t3_no_pending_emit", 64'(p), 0);
        timeNow = 29'd0;
        push_a(7, 1);
        push_a(7, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_replay_rdAddr", 64'(rdAddr), 0);
        check("t3_replay_timerClear", 64'(timerClear), 1);
        ticks_to_valid(1'b0, 10, n);
        check("t3_replay_latency", 64'(n), 3);
        timeNow = 29'd1000;
        ticks_to_valid(1'b0, 10, n);
        check("t3_back_to_back_spacing", 64'(n), 4);
        tick();
        check("t3_done", 64'(done), 1);

        // ---------------- time limit boundary / end marker ----------------
        mem[0] = ev(0, 1, 9, 0);
        mem[1] = ev(0, 1, 10, 300000000);
        mem[2] = ev(0, 0, 9, 300000001);
        mem[3] = ev(1, 0, 9, 0);
        timeNow = 29'd300000000;
        push_a(9, 1);
        push_a(10, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks_to_valid(1'b0, 10, n);
        check("t4_first_note_latency", 64'(n), 3);
        ticks_to_valid(1'b0, 10, n);
        check("t4_max_ts_note_latency", 64'(n), 4);
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        check("t4_end_marker_to_done", 64'(n), 3);
        check("t4_final_rdAddr", 64'(rdAddr), 2);
        check("t4_queue_drained", 64'(q_a.size()), 0);

        // ---------------- async reset mid-WAIT, start+stop in IDLE ----------------
        mem[0] = ev(1, 1, 12, 5000);
        timeNow = 29'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t5_waiting_busy", 64'(busy), 1);
        #2 resetn = 1'b1;
        #1;
        check("t5_async_busy", 64'(busy), 0);
        check("t5_async_timerEnable", 64'(timerEnable), 0);
        check("t5_async_rdAddr", 64'(rdAddr), 0);
        check("t5_async_noteIndex", 64'(noteIndex), 0);
        check("t5_async_noteOn", 64'(noteOn), 0);
        tick();
        resetn = 1'b0;
        timeNow = 29'd5000;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t5_startstop_busy", 64'(busy), 0);
        check("t5_startstop_timerClear", 64'(timerClear), 0);
        check("t5_startstop_timerEnable", 64'(timerEnable), 0);
        check("t5_startstop_done", 64'(done), 0);
        count_pulses(6, p);
        check("t5_no_note_after_reset", 64'(p), 0);
        check("t5_still_idle", 64'(busy), 0);

        // ---------------- 2-bit address wrap ----------------
        for (int i = 0; i < 4; i++) begin
            mem_b[i] = ev(0, i % 2, i + 1, 0);
            push_b(i + 1, i % 2);
        end
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        ticks_to_valid(1'b1, 10, n);
        check("t6_first_note_latency", 64'(n), 3);
        for (int k = 1; k < 4; k++) begin
            ticks_to_valid(1'b1, 10, n);
            check("t6_note_spacing", 64'(n), 4);
        end
        tick();
        check("t6_done", 64'(done_b), 1);
        check("t6_timerEnable_off", 64'(timerEnable_b), 0);
        check("t6_final_rdAddr", 64'(rdAddr_b), 3);
        check("t6_no_wrap", 64'(wrap_b), 0);
        repeat (4) tick();
        check("t6_queue_drained", 64'(q_b.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
